// File: rtl/folded_history_tracker_pkg.sv
// Shared branch-predictor definitions: tracker FSM states and per-channel history lengths.
package folded_history_tracker_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StRecomp = 1'b1
  } fht_state_e;

  // Channel c folds the newest (ghr_len >> (num_ch-1-c)) history bits.
  function automatic int unsigned chan_len(input int unsigned ghr_len,
                                           input int unsigned num_ch,
                                           input int unsigned c);
    return ghr_len >> (num_ch - 1 - c);
  endfunction

endpackage

// File: rtl/folded_history_tracker_fold.sv
// Combinational fold: XOR of all OUT_LENGTH-bit chunks of the input, top chunk zero-padded.
module history_fold #(
  parameter int unsigned IN_LENGTH  = 64,
  parameter int unsigned OUT_LENGTH = 8
) (
  input  logic [IN_LENGTH-1:0]  data_i,
  output logic [OUT_LENGTH-1:0] fold_o
);

  always_comb begin
    fold_o = '0;
    for (int unsigned i = 0; i < IN_LENGTH; i++) begin
      fold_o[i % OUT_LENGTH] = fold_o[i % OUT_LENGTH] ^ data_i[i];
    end
  end

endmodule

// File: rtl/folded_history_tracker.sv
// Global history register with incrementally maintained folded copies and
// sequential full recompute after a checkpoint restore.
module folded_history_tracker
  import folded_history_tracker_pkg::*;
#(
  parameter int unsigned GHR_LENGTH   = 64,
  parameter int unsigned FOLD_LENGTH  = 8,
  parameter int unsigned NUM_CHANNELS = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                update_valid_i,
  input  logic                                update_taken_i,
  input  logic                                restore_valid_i,
  input  logic [GHR_LENGTH-1:0]               restore_ghr_i,
  output logic                                ready_o,
  output logic [GHR_LENGTH-1:0]               ghr_o,
  output logic [NUM_CHANNELS*FOLD_LENGTH-1:0] fold_o
);

  localparam int unsigned IdxW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  if ((NUM_CHANNELS < 1) || (FOLD_LENGTH < 1) ||
      ((GHR_LENGTH % (2 ** (NUM_CHANNELS - 1))) != 0) ||
      ((GHR_LENGTH >> (NUM_CHANNELS - 1)) < FOLD_LENGTH)) begin : gen_param_err
    $error("folded_history_tracker: illegal GHR_LENGTH/FOLD_LENGTH/NUM_CHANNELS combination");
  end

  logic [GHR_LENGTH-1:0]               ghr_q;
  logic [NUM_CHANNELS*FOLD_LENGTH-1:0] fold_q;
  logic [NUM_CHANNELS*FOLD_LENGTH-1:0] fold_inc;
  fht_state_e                          state_q;
  logic [IdxW-1:0]                     idx_q;
  logic                                ready_q;
  logic [GHR_LENGTH-1:0]               fold_src;
  logic [FOLD_LENGTH-1:0]              fold_full;

  // Present only the indexed channel's history span to the shared folder.
  always_comb begin
    fold_src = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (idx_q == IdxW'(c)) begin
        for (int unsigned b = 0; b < GHR_LENGTH; b++) begin
          if (b < chan_len(GHR_LENGTH, NUM_CHANNELS, c)) begin
            fold_src[b] = ghr_q[b];
          end
        end
      end
    end
  end

  history_fold #(
    .IN_LENGTH  (GHR_LENGTH),
    .OUT_LENGTH (FOLD_LENGTH)
  ) u_history_fold (
    .data_i (fold_src),
    .fold_o (fold_full)
  );

  // Incremental update: shifting the history rotates every chunk position by one;
  // the new bit enters at position 0 and the bit leaving the window is cancelled.
  always_comb begin : p_fold_inc
    logic [FOLD_LENGTH-1:0] old_f;
    logic [FOLD_LENGTH-1:0] new_f;
    int unsigned            len;
    fold_inc = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      len   = chan_len(GHR_LENGTH, NUM_CHANNELS, c);
      old_f = fold_q[c*FOLD_LENGTH +: FOLD_LENGTH];
      new_f = '0;
      for (int unsigned i = 0; i < FOLD_LENGTH; i++) begin
        new_f[(i + 1) % FOLD_LENGTH] = old_f[i];
      end
      new_f[0]                 = new_f[0] ^ update_taken_i;
      new_f[len % FOLD_LENGTH] = new_f[len % FOLD_LENGTH] ^ ghr_q[len - 1];
      fold_inc[c*FOLD_LENGTH +: FOLD_LENGTH] = new_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q   <= '0;
      fold_q  <= '0;
      state_q <= StIdle;
      idx_q   <= '0;
      ready_q <= 1'b1;
    end else if (restore_valid_i) begin
      // Restore wins over any concurrent update and restarts recompute from channel 0.
      ghr_q   <= restore_ghr_i;
      state_q <= StRecomp;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (update_valid_i) begin
            ghr_q  <= {ghr_q[GHR_LENGTH-2:0], update_taken_i};
            fold_q <= fold_inc;
          end
        end
        StRecomp: begin
          for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (idx_q == IdxW'(c)) begin
              fold_q[c*FOLD_LENGTH +: FOLD_LENGTH] <= fold_full;
            end
          end
          if (idx_q == IdxW'(NUM_CHANNELS - 1)) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= '0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign ghr_o   = ghr_q;
  assign fold_o  = fold_q;

endmodule

// File: tb/tb_folded_history_tracker.sv
// Directed vector table plus randomized model check for folded_history_tracker (16/4/2).
module tb_folded_history_tracker;

  localparam int unsigned G = 16;
  localparam int unsigned F = 4;
  localparam int unsigned N = 2;

  logic         clk;
  logic         rst_n;
  logic         update_valid_i;
  logic         update_taken_i;
  logic         restore_valid_i;
  logic [G-1:0] restore_ghr_i;
  logic         ready_o;
  logic [G-1:0] ghr_o;
  logic [N*F-1:0] fold_o;

  folded_history_tracker #(
    .GHR_LENGTH   (G),
    .FOLD_LENGTH  (F),
    .NUM_CHANNELS (N)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .update_valid_i  (update_valid_i),
    .update_taken_i  (update_taken_i),
    .restore_valid_i (restore_valid_i),
    .restore_ghr_i   (restore_ghr_i),
    .ready_o         (ready_o),
    .ghr_o           (ghr_o),
    .fold_o          (fold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rv;
    logic [15:0] rg;
    logic        uv;
    logic        ut;
    logic        er;
    logic [15:0] eg;
    logic        cf;
    logic [7:0]  ef;
  } vec_t;

  vec_t vecs [14];
  int   n_vec;
  int   n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_fold(input logic [15:0] g, input int len);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[i % 4] = r[i % 4] ^ g[i];
    return r;
  endfunction

  task automatic drive(input logic rv, input logic [15:0] rg, input logic uv, input logic ut);
    restore_valid_i = rv;
    restore_ghr_i   = rg;
    update_valid_i  = uv;
    update_taken_i  = ut;
  endtask

  initial begin
    logic [15:0] mg;
    int          busy;
    logic        rv, uv, ut;
    logic [15:0] rg;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    //              rv    rg        uv    ut    er    eg        cf    ef
    vecs[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 8'h11};
    vecs[1]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 8'h47};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h2469, 1'b1, 8'h9F};
    vecs[5]  = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 8'h00};
    vecs[8]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 16'h00F0, 1'b1, 1'b1, 1'b0, 16'h00F0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h00F0, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00F0, 1'b1, 8'hFF};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h01E0, 1'b1, 8'hFE};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h03C1, 1'b1, 8'hED};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ghr", 32'(ghr_o), 32'h0);
    chk("reset_fold", 32'(fold_o), 32'h0);
    chk("reset_ready", 32'(ready_o), 32'h1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].rv, vecs[i].rg, vecs[i].uv, vecs[i].ut);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(vecs[i].er));
      chk($sformatf("vec%0d_ghr", i), 32'(ghr_o), 32'(vecs[i].eg));
      if (vecs[i].cf) chk($sformatf("vec%0d_fold", i), 32'(fold_o), 32'(vecs[i].ef));
    end

    // Randomized run against a cycle model; folds checked whenever ready.
    mg   = 16'h03C1;
    busy = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      rv = ($urandom_range(0, 15) == 0);
      rg = 16'($urandom);
      uv = 1'($urandom);
      ut = 1'($urandom);
      drive(rv, rg, uv, ut);
      @(posedge clk);
      if (rv) begin
        mg   = rg;
        busy = N;
      end else if (busy > 0) begin
        busy--;
      end else if (uv) begin
        mg = {mg[14:0], ut};
      end
      #1;
      chk("rand_ghr", 32'(ghr_o), 32'(mg));
      chk("rand_ready", 32'(ready_o), 32'(busy == 0));
      if (busy == 0) chk("rand_fold", 32'(fold_o), 32'({ref_fold(mg, 16), ref_fold(mg, 8)}));
    end

    // Asynchronous reset in the middle of a recompute.
    @(negedge clk);
    drive(1'b1, 16'hABCD, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("midrc_ready", 32'(ready_o), 32'h0);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ghr", 32'(ghr_o), 32'h0);
    chk("async_rst_fold", 32'(fold_o), 32'h0);
    chk("async_rst_ready", 32'(ready_o), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(ready_o), 32'h1);
    chk("post_rst_ghr", 32'(ghr_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
